atm_keypad_frontend: RTL

ATM_KEYPAD_FRONTEND -- requirements
Module: atm_keypad_frontend

---
 rtl/atm_keypad_frontend.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/atm_keypad_frontend.sv
// ATM keypad front end: collects account, PIN, operation and amount from key strobes,
// issues the request to the ATM and tracks its response or a timeout.
module atm_keypad_frontend #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic        lang_sel,
   input  logic [2:0]  atm_state,
   input  logic        atm_success,
   input  logic [31:0] atm_balance,
   output logic [3:0]  acc_num,
   output logic [15:0] pin,
   output logic [15:0] new_pin,
   output logic [31:0] amount,
   output logic [2:0]  operation,
   output logic        language,
   output logic        busy,
   output logic        done,
   output logic [1:0]  err,
   output logic [31:0] result_balance
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   localparam logic [3:0] KeyEnter     = 4'hA;
   localparam logic [3:0] KeyCancel    = 4'hB;
   localparam logic [3:0] KeyBalance   = 4'hC;
   localparam logic [3:0] KeyWithdraw  = 4'hD;
   localparam logic [3:0] KeyDeposit   = 4'hE;
   localparam logic [3:0] KeyChangePin = 4'hF;

   localparam logic [2:0] AtmWaiting = 3'd1;
   localparam logic [2:0] AtmMenu    = 3'd2;

   localparam logic [1:0] ErrOk      = 2'd0;
   localparam logic [1:0] ErrDenied  = 2'd1;
   localparam logic [1:0] ErrTimeout = 2'd2;
   localparam logic [1:0] ErrAbort   = 2'd3;

   typedef enum logic [2:0] {
      StAcc, StPin, StOp, StAmt, StNewPin, StIssue, StWait, StDone
   } state_e;

   state_e            state_q, state_d;
   logic [3:0]        acc_q;
   logic [15:0]       pin_q, new_pin_q;
   logic [31:0]       amount_q, rbal_q;
   logic [2:0]        op_q;
   logic              lang_q, busy_q, seen_q;
   logic [1:0]        err_q, fin_err;
   logic [3:0]        dig_cnt_q;
   logic [CntW-1:0]   tmo_cnt_q;
   logic              is_digit, is_enter, is_cancel, tmo;

   assign is_digit  = key_valid && (key_code <= 4'd9);
   assign is_enter  = key_valid && (key_code == KeyEnter);
   assign is_cancel = key_valid && (key_code == KeyCancel);
   assign tmo       = (tmo_cnt_q == CntLast);

   always_ff @(posedge clk) begin
      if (!rst) state_q <= StAcc;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      fin_err = ErrOk;
      unique case (state_q)
         StAcc: begin
            if (is_cancel && busy_q) begin
               state_d = StDone;
               fin_err = ErrAbort;
            end else if (is_enter) begin
               if (dig_cnt_q != 4'd0) begin
                  state_d = StPin;
               end else begin
                  state_d = StDone;
                  fin_err = ErrAbort;
               end
            end
         end
         StPin, StNewPin: begin
            if (is_cancel || (is_enter && dig_cnt_q != 4'd4)) begin
               state_d = StDone;
               fin_err = ErrAbort;
            end else if (is_enter) begin
               state_d = (state_q == StPin) ? StOp : StIssue;
            end
         end
         StOp: begin
            if (is_cancel) begin
               state_d = StDone;
               fin_err = ErrAbort;
            end else if (key_valid) begin
               case (key_code)
                  KeyBalance:              state_d = StIssue;
                  KeyWithdraw, KeyDeposit: state_d = StAmt;
                  KeyChangePin:            state_d = StNewPin;
                  default:                 ;
               endcase
            end
         end
         StAmt: begin
            if (is_cancel || (is_enter && dig_cnt_q == 4'd0)) begin
               state_d = StDone;
               fin_err = ErrAbort;
            end else if (is_enter) begin
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (tmo) begin
               state_d = StDone;
               fin_err = ErrTimeout;
            end else if (atm_state == AtmMenu) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (tmo) begin
               state_d = StDone;
               fin_err = ErrTimeout;
            end else if (seen_q && atm_state == AtmWaiting) begin
               state_d = StDone;
               fin_err = atm_success ? ErrOk : ErrDenied;
            end
         end
         StDone: state_d = StAcc;
      endcase
   end

   always_comb begin
      done      = (state_q == StDone);
      operation = 3'd0;
      if (state_q == StWait || (state_q == StIssue && state_d == StWait)) operation = op_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc_q     <= '0;
         pin_q     <= '0;
         new_pin_q <= '0;
         amount_q  <= '0;
         rbal_q    <= '0;
         op_q      <= '0;
         lang_q    <= 1'b0;
         busy_q    <= 1'b0;
         seen_q    <= 1'b0;
         err_q     <= ErrOk;
         dig_cnt_q <= '0;
         tmo_cnt_q <= '0;
      end else if (state_d == StDone) begin
         acc_q     <= '0;
         pin_q     <= '0;
         new_pin_q <= '0;
         amount_q  <= '0;
         op_q      <= '0;
         busy_q    <= 1'b0;
         dig_cnt_q <= '0;
         err_q     <= fin_err;
         // Balance is only taken on a real ATM completion, never on timeout.
         if (state_q == StWait && !tmo) rbal_q <= atm_balance;
      end else begin
         if (state_d != state_q) dig_cnt_q <= '0;
         if (state_d == StIssue && state_q != StIssue) begin
            tmo_cnt_q <= '0;
            seen_q    <= 1'b0;
         end else if (state_q == StIssue || state_q == StWait) begin
            tmo_cnt_q <= tmo_cnt_q + CntW'(1);
         end
         case (state_q)
            StAcc: if (is_digit) begin
               acc_q     <= key_code;
               busy_q    <= 1'b1;
               err_q     <= ErrOk;
               dig_cnt_q <= 4'd1;
               if (!busy_q) lang_q <= lang_sel;
            end
            StPin: if (is_digit && dig_cnt_q < 4'd4) begin
               pin_q     <= {pin_q[11:0], key_code};
               dig_cnt_q <= dig_cnt_q + 4'd1;
            end
            StNewPin: if (is_digit && dig_cnt_q < 4'd4) begin
               new_pin_q <= {new_pin_q[11:0], key_code};
               dig_cnt_q <= dig_cnt_q + 4'd1;
            end
            StOp: if (key_valid) begin
               case (key_code)
                  KeyBalance:   op_q <= 3'd3;
                  KeyWithdraw:  op_q <= 3'd4;
                  KeyDeposit:   op_q <= 3'd5;
                  KeyChangePin: op_q <= 3'd6;
                  default:      ;
               endcase
            end
            // Nine decimal digits always fit in 32 bits.
            StAmt: if (is_digit && dig_cnt_q < 4'd9) begin
               amount_q  <= amount_q * 32'd10 + 32'(key_code);
               dig_cnt_q <= dig_cnt_q + 4'd1;
            end
            StWait: if (atm_state == op_q) seen_q <= 1'b1;
            default: ;
         endcase
      end
   end

   assign acc_num        = acc_q;
   assign pin            = pin_q;
   assign new_pin        = new_pin_q;
   assign amount         = amount_q;
   assign language       = lang_q;
   assign busy           = busy_q;
   assign err            = err_q;
   assign result_balance = rbal_q;

endmodule
